// File: rtl/l2_vc_pkg.sv
// Shared types and constants for the L2-side victim-cache requester.
package l2_vc_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        PUSH   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/l2_victim_requester_if.sv
// L2 miss/evict request side plus victim-cache request side, with statistics.
interface l2_victim_requester_if #(
    parameter int CNT_W = 16
);
    import l2_vc_pkg::*;

    logic                 l2_req;
    logic                 l2_ready;
    logic [ADDR_W-1:0]    l2_address;
    logic                 l2_evict_valid;
    logic [ADDR_W-1:0]    l2_evict_address;
    logic [LINE_W-1:0]    l2_evict_data;
    logic                 l2_done;
    logic [LINE_W-1:0]    l2_fill_data;
    logic                 l2_fill_hit;
    logic                 l2_err;

    logic                 vc_read;
    logic                 vc_write;
    logic [ADDR_W-1:0]    vc_address;
    logic [ADDR_W-1:0]    vc_lru_address;
    logic [LINE_W-1:0]    vc_wdata;
    logic [LINE_W-1:0]    vc_rdata;
    logic                 vc_hit;
    logic                 vc_resp;

    logic [CNT_W-1:0]     hit_count;
    logic [CNT_W-1:0]     miss_count;

    modport master (
        input  l2_req, l2_address, l2_evict_valid, l2_evict_address, l2_evict_data,
        input  vc_rdata, vc_hit, vc_resp,
        output l2_ready, l2_done, l2_fill_data, l2_fill_hit, l2_err,
        output vc_read, vc_write, vc_address, vc_lru_address, vc_wdata,
        output hit_count, miss_count
    );

    modport slave (
        output l2_req, l2_address, l2_evict_valid, l2_evict_address, l2_evict_data,
        output vc_rdata, vc_hit, vc_resp,
        input  l2_ready, l2_done, l2_fill_data, l2_fill_hit, l2_err,
        input  vc_read, vc_write, vc_address, vc_lru_address, vc_wdata,
        input  hit_count, miss_count
    );

endinterface

// File: rtl/l2_vc_sat_counter.sv
// Saturating up-counter; sticks at all-ones. Registered, 1-cycle update latency.
module l2_vc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] out_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_o = cnt_q;

endmodule

// File: rtl/l2_victim_requester.sv
// L2 miss -> victim-cache lookup, then optional victim push; l2_done 2 cycles after accept (3 with evict).
// One transaction in flight: l2_ready only in IDLE; vc_resp may stall each phase up to TIMEOUT_CYCLES.
module l2_victim_requester
    import l2_vc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    l2_victim_requester_if.master         req_if
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   addr_q;
    logic                evict_vld_q;
    logic [ADDR_W-1:0]   evict_addr_q;
    logic [LINE_W-1:0]   evict_dat_q;
    logic [LINE_W-1:0]   fill_dat_q;
    logic                fill_hit_q;

    logic                latch_req;
    logic                lookup_done;
    logic                tmo_expire;

    assign tmo_expire = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        latch_req   = 1'b0;
        lookup_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_if.l2_req) begin
                    latch_req = 1'b1;
                    err_d     = 1'b0;
                    tmo_d     = '0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_if.vc_resp) begin
                    lookup_done = 1'b1;
                    tmo_d       = '0;
                    state_d     = evict_vld_q ? PUSH : DONE;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            PUSH: begin
                if (req_if.vc_resp) begin
                    state_d = DONE;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Request fields are frozen at acceptance; later input changes must not leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            evict_vld_q  <= 1'b0;
            evict_addr_q <= '0;
            evict_dat_q  <= '0;
        end else if (latch_req) begin
            addr_q       <= line_addr(req_if.l2_address);
            evict_vld_q  <= req_if.l2_evict_valid;
            evict_addr_q <= line_addr(req_if.l2_evict_address);
            evict_dat_q  <= req_if.l2_evict_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_dat_q <= '0;
            fill_hit_q <= 1'b0;
        end else if (lookup_done) begin
            fill_dat_q <= req_if.vc_rdata;
            fill_hit_q <= req_if.vc_hit;
        end
    end

    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    l2_vc_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (lookup_done && req_if.vc_hit),
        .out_o (hit_cnt)
    );

    l2_vc_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (lookup_done && !req_if.vc_hit),
        .out_o (miss_cnt)
    );

    assign req_if.l2_ready       = (state_q == IDLE);
    assign req_if.l2_done        = (state_q == DONE);
    assign req_if.l2_err         = (state_q == DONE) && err_q;
    assign req_if.l2_fill_data   = fill_dat_q;
    assign req_if.l2_fill_hit    = fill_hit_q;
    assign req_if.vc_read        = (state_q == LOOKUP);
    assign req_if.vc_write       = (state_q == PUSH);
    assign req_if.vc_address     = addr_q;
    assign req_if.vc_lru_address = evict_addr_q;
    assign req_if.vc_wdata       = evict_dat_q;
    assign req_if.hit_count      = hit_cnt;
    assign req_if.miss_count     = miss_cnt;

endmodule
